// File: rtl/debug_cmd_responder.sv
// MIPS-side debug link endpoint: decodes MicroBlaze command frames,
// drives pipeline run control, imem writes and debug reads.
// Ports: i_clock/i_reset (sync, active-high), i_frame_from_blaze,
//   o_frame_to_blaze, i_halt, o_pipe_reset, o_pipe_enable,
//   o_imem_we/addr/data, o_rd_req/type/addr, i_rd_data.
module debug_cmd_responder #(
  parameter int NB_CONTROL_FRAME = 32,
  parameter int NB_CODE          = 6,
  parameter int NB_ADDR_TYPE     = 9,
  parameter int NB_ADDR_DATA     = 16,
  parameter int NB_INSTR         = 32
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic [NB_CONTROL_FRAME-1:0] i_frame_from_blaze,
  output logic [NB_CONTROL_FRAME-1:0] o_frame_to_blaze,
  input  logic                        i_halt,
  output logic                        o_pipe_reset,
  output logic                        o_pipe_enable,
  output logic                        o_imem_we,
  output logic [NB_ADDR_TYPE-1:0]     o_imem_addr,
  output logic [NB_INSTR-1:0]         o_imem_data,
  output logic                        o_rd_req,
  output logic [NB_ADDR_TYPE-1:0]     o_rd_type,
  output logic [NB_ADDR_DATA-1:0]     o_rd_addr,
  input  logic [NB_INSTR-1:0]         i_rd_data
);

  localparam int NB_PAD = NB_CONTROL_FRAME - NB_CODE - 3 - NB_ADDR_DATA;
  localparam int NB_HI  = NB_INSTR - NB_ADDR_DATA;

  localparam logic [NB_CODE-1:0] C_START     = 6'b000001;
  localparam logic [NB_CODE-1:0] C_RESET     = 6'b000010;
  localparam logic [NB_CODE-1:0] C_REQ_DATA  = 6'b000011;
  localparam logic [NB_CODE-1:0] C_LOAD_LSB  = 6'b000100;
  localparam logic [NB_CODE-1:0] C_LOAD_MSB  = 6'b000101;
  localparam logic [NB_CODE-1:0] C_MODE_GET  = 6'b001000;
  localparam logic [NB_CODE-1:0] C_MODE_CONT = 6'b001001;
  localparam logic [NB_CODE-1:0] C_MODE_STEP = 6'b001010;
  localparam logic [NB_CODE-1:0] C_STEP      = 6'b100000;
  localparam logic [NB_CODE-1:0] C_GOT_DATA  = 6'b100100;
  localparam logic [NB_CODE-1:0] C_GIB_DATA  = 6'b100101;

  localparam logic [NB_CODE-1:0] R_IDLE = 6'b000000;
  localparam logic [NB_CODE-1:0] R_ACK  = 6'b000001;
  localparam logic [NB_CODE-1:0] R_LSB  = 6'b000010;
  localparam logic [NB_CODE-1:0] R_MSB  = 6'b000011;
  localparam logic [NB_CODE-1:0] R_MODE = 6'b000100;
  localparam logic [NB_CODE-1:0] R_ERR  = 6'b111111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD_WAIT,
    S_SEND_LSB,
    S_SEND_MSB
  } state_t;

  logic [NB_CODE-1:0]      code;
  logic                    vld;
  logic [NB_ADDR_TYPE-1:0] at;
  logic [NB_ADDR_DATA-1:0] ad;

  assign code = i_frame_from_blaze[NB_CONTROL_FRAME-1 -: NB_CODE];
  assign vld  = i_frame_from_blaze[NB_ADDR_DATA+NB_ADDR_TYPE];
  assign at   = i_frame_from_blaze[NB_ADDR_DATA +: NB_ADDR_TYPE];
  assign ad   = i_frame_from_blaze[NB_ADDR_DATA-1:0];

  state_t                  state_q, state_d;
  logic                    mode_q, mode_d;
  logic                    running_q, running_d;
  logic                    prev_vld_q, prev_vld_d;
  logic [NB_CODE-1:0]      prev_code_q, prev_code_d;
  logic [NB_CODE-1:0]      reply_q, reply_d;
  logic [NB_ADDR_DATA-1:0] data_q, data_d;
  logic [NB_ADDR_DATA-1:0] lsb_buf_q, lsb_buf_d;
  logic [NB_HI-1:0]        hold_q, hold_d;
  logic                    pipe_reset_q, pipe_reset_d;
  logic                    pipe_en_q, pipe_en_d;
  logic                    imem_we_q, imem_we_d;
  logic [NB_ADDR_TYPE-1:0] imem_addr_q, imem_addr_d;
  logic [NB_INSTR-1:0]     imem_data_q, imem_data_d;
  logic                    rd_req_q, rd_req_d;
  logic [NB_ADDR_TYPE-1:0] rd_type_q, rd_type_d;
  logic [NB_ADDR_DATA-1:0] rd_addr_q, rd_addr_d;

  logic accept;
  logic is_reset;
  logic step_pulse;

  // A held frame is seen once: only a rising valid or a new code counts.
  assign accept   = vld & (~prev_vld_q | (code != prev_code_q));
  assign is_reset = accept & (code == C_RESET);

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    running_d    = running_q;
    prev_vld_d   = vld;
    prev_code_d  = code;
    reply_d      = reply_q;
    data_d       = data_q;
    lsb_buf_d    = lsb_buf_q;
    hold_d       = hold_q;
    pipe_reset_d = 1'b0;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_data_d  = imem_data_q;
    rd_req_d     = 1'b0;
    rd_type_d    = rd_type_q;
    rd_addr_d    = rd_addr_q;
    step_pulse   = 1'b0;

    if (is_reset) begin
      state_d      = S_IDLE;
      mode_d       = 1'b0;
      running_d    = 1'b0;
      pipe_reset_d = 1'b1;
      reply_d      = R_ACK;
      data_d       = '0;
      hold_d       = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            reply_d = R_ACK;
            data_d  = '0;
            case (code)
              C_START:     running_d = 1'b1;
              C_MODE_CONT: mode_d    = 1'b0;
              C_MODE_STEP: mode_d    = 1'b1;
              C_MODE_GET: begin
                reply_d = R_MODE;
                data_d  = {{(NB_ADDR_DATA-1){1'b0}}, mode_q};
              end
              C_STEP: begin
                if (mode_q && running_q) step_pulse = 1'b1;
                else reply_d = R_ERR;
              end
              C_LOAD_LSB:  lsb_buf_d = ad;
              C_LOAD_MSB: begin
                imem_we_d   = 1'b1;
                imem_addr_d = at;
                imem_data_d = {ad, lsb_buf_q};
              end
              C_REQ_DATA: begin
                reply_d   = reply_q;
                data_d    = data_q;
                rd_req_d  = 1'b1;
                rd_type_d = at;
                rd_addr_d = ad;
                state_d   = S_RD_WAIT;
              end
              default:     reply_d = R_ERR;
            endcase
          end
        end
        S_RD_WAIT: begin
          // Data is valid the cycle after the strobe, i.e. once
          // the strobe has dropped.
          if (!rd_req_q) begin
            hold_d  = i_rd_data[NB_INSTR-1:NB_ADDR_DATA];
            reply_d = R_LSB;
            data_d  = i_rd_data[NB_ADDR_DATA-1:0];
            state_d = S_SEND_LSB;
          end
        end
        S_SEND_LSB: begin
          if (accept) begin
            if (code == C_GIB_DATA) begin
              reply_d = R_MSB;
              data_d  = hold_q;
              state_d = S_SEND_MSB;
            end else begin
              reply_d = R_ERR;
              data_d  = '0;
              hold_d  = '0;
              state_d = S_IDLE;
            end
          end
        end
        S_SEND_MSB: begin
          if (accept) begin
            reply_d = (code == C_GOT_DATA) ? R_ACK : R_ERR;
            data_d  = '0;
            hold_d  = '0;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // HALT wins over a START in the same cycle.
    if (i_halt) running_d = 1'b0;

    pipe_en_d = step_pulse | (running_q & ~mode_q & ~is_reset);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q      <= S_IDLE;
      mode_q       <= 1'b0;
      running_q    <= 1'b0;
      prev_vld_q   <= 1'b0;
      prev_code_q  <= '0;
      reply_q      <= R_IDLE;
      data_q       <= '0;
      lsb_buf_q    <= '0;
      hold_q       <= '0;
      pipe_reset_q <= 1'b0;
      pipe_en_q    <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_data_q  <= '0;
      rd_req_q     <= 1'b0;
      rd_type_q    <= '0;
      rd_addr_q    <= '0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      running_q    <= running_d;
      prev_vld_q   <= prev_vld_d;
      prev_code_q  <= prev_code_d;
      reply_q      <= reply_d;
      data_q       <= data_d;
      lsb_buf_q    <= lsb_buf_d;
      hold_q       <= hold_d;
      pipe_reset_q <= pipe_reset_d;
      pipe_en_q    <= pipe_en_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_data_q  <= imem_data_d;
      rd_req_q     <= rd_req_d;
      rd_type_q    <= rd_type_d;
      rd_addr_q    <= rd_addr_d;
    end
  end

  assign o_frame_to_blaze = {reply_q, (state_q != S_IDLE), mode_q,
                             running_q, {NB_PAD{1'b0}}, data_q};
  assign o_pipe_reset  = pipe_reset_q;
  assign o_pipe_enable = pipe_en_q;
  assign o_imem_we     = imem_we_q;
  assign o_imem_addr   = imem_addr_q;
  assign o_imem_data   = imem_data_q;
  assign o_rd_req      = rd_req_q;
  assign o_rd_type     = rd_type_q;
  assign o_rd_addr     = rd_addr_q;

endmodule

// File: tb/tb_debug_cmd_responder.sv
// Scoreboard bench for debug_cmd_responder: stimulus queues
// cycle-tagged expectations, a negedge monitor checks them.
module tb_debug_cmd_responder;

  localparam logic [5:0] C_START    = 6'b000001;
  localparam logic [5:0] C_RESET    = 6'b000010;
  localparam logic [5:0] C_REQ      = 6'b000011;
  localparam logic [5:0] C_LSB      = 6'b000100;
  localparam logic [5:0] C_MSB      = 6'b000101;
  localparam logic [5:0] C_MGET     = 6'b001000;
  localparam logic [5:0] C_MSTEP    = 6'b001010;
  localparam logic [5:0] C_STEP     = 6'b100000;
  localparam logic [5:0] C_GOT      = 6'b100100;
  localparam logic [5:0] C_GIB      = 6'b100101;
  localparam logic [5:0] C_BAD      = 6'b111000;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [31:0] i_frame = '0;
  logic [31:0] o_frame;
  logic        i_halt = 1'b0;
  logic        o_pipe_reset, o_pipe_enable, o_imem_we, o_rd_req;
  logic [8:0]  o_imem_addr, o_rd_type;
  logic [31:0] o_imem_data;
  logic [15:0] o_rd_addr;
  logic [31:0] i_rd_data = '0;

  always #5 clk = ~clk;

  debug_cmd_responder dut (
    .i_clock            (clk),
    .i_reset            (i_reset),
    .i_frame_from_blaze (i_frame),
    .o_frame_to_blaze   (o_frame),
    .i_halt             (i_halt),
    .o_pipe_reset       (o_pipe_reset),
    .o_pipe_enable      (o_pipe_enable),
    .o_imem_we          (o_imem_we),
    .o_imem_addr        (o_imem_addr),
    .o_imem_data        (o_imem_data),
    .o_rd_req           (o_rd_req),
    .o_rd_type          (o_rd_type),
    .o_rd_addr          (o_rd_addr),
    .i_rd_data          (i_rd_data)
  );

  typedef enum int {
    F_FRAME, F_REPLY, F_DATA, F_BUSY, F_MODE, F_RUN, F_PRST,
    F_PEN, F_IWE, F_IADDR, F_IDATA, F_RREQ, F_RTYPE, F_RADDR
  } fld_t;

  typedef struct {
    int          cyc;
    fld_t        f;
    logic [31:0] v;
    string       name;
  } exp_t;

  exp_t sb[$];
  int edge_n = 0;
  int n_checks = 0;
  int n_fail = 0;
  int cnt_prst = 0;
  int cnt_iwe = 0;
  int cnt_rreq = 0;

  always @(posedge clk) edge_n <= edge_n + 1;

  function automatic logic [31:0] mem_val(logic [8:0] t, logic [15:0] a);
    if (t == 9'd2 && a == 16'd3) return 32'hDEADBEEF;
    if (t == 9'd2 && a == 16'd7) return 32'h12345678;
    return 32'hA5A50000 | {16'h0, a};
  endfunction

  // Read port: data valid exactly the cycle after the strobe.
  always @(posedge clk) begin
    if (o_rd_req) i_rd_data <= mem_val(o_rd_type, o_rd_addr);
    else          i_rd_data <= '0;
  end

  function automatic logic [31:0] peek(fld_t f);
    case (f)
      F_FRAME: return o_frame;
      F_REPLY: return {26'h0, o_frame[31:26]};
      F_DATA:  return {16'h0, o_frame[15:0]};
      F_BUSY:  return {31'h0, o_frame[25]};
      F_MODE:  return {31'h0, o_frame[24]};
      F_RUN:   return {31'h0, o_frame[23]};
      F_PRST:  return {31'h0, o_pipe_reset};
      F_PEN:   return {31'h0, o_pipe_enable};
      F_IWE:   return {31'h0, o_imem_we};
      F_IADDR: return {23'h0, o_imem_addr};
      F_IDATA: return o_imem_data;
      F_RREQ:  return {31'h0, o_rd_req};
      F_RTYPE: return {23'h0, o_rd_type};
      default: return {16'h0, o_rd_addr};
    endcase
  endfunction

  task automatic expect_at(int c, fld_t f, logic [31:0] v, string n);
    exp_t e;
    int i;
    e.cyc = c;
    e.f = f;
    e.v = v;
    e.name = n;
    i = sb.size();
    while (i > 0 && sb[i-1].cyc > c) i--;
    sb.insert(i, e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (o_pipe_reset) cnt_prst++;
    if (o_imem_we) cnt_iwe++;
    if (o_rd_req) cnt_rreq++;
    while (sb.size() > 0 && sb[0].cyc <= edge_n) begin
      e = sb.pop_front();
      n_checks++;
      if (e.cyc != edge_n) begin
        n_fail++;
        $display("FAIL %s: check for cycle %0d missed (now %0d)",
                 e.name, e.cyc, edge_n);
      end else if (peek(e.f) !== e.v) begin
        n_fail++;
        $display("FAIL %s: cycle %0d got %h expected %h",
                 e.name, edge_n, peek(e.f), e.v);
      end
    end
  end

  task automatic drive(logic [5:0] c, logic [8:0] t, logic [15:0] a,
                       output int b);
    @(posedge clk);
    #1;
    i_frame = {c, 1'b1, t, a};
    b = edge_n;
  endtask

  task automatic finish_cmd();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    i_frame[25] = 1'b0;
  endtask

  task automatic check_count(string n, int got, int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", n, got, want);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    int b2;
    int k;

    // reset state
    @(posedge clk);
    #1;
    b = edge_n;
    expect_at(b+1, F_FRAME, 32'h0, "rst_frame");
    expect_at(b+1, F_PRST,  0, "rst_prst");
    expect_at(b+1, F_PEN,   0, "rst_pen");
    expect_at(b+1, F_IWE,   0, "rst_iwe");
    expect_at(b+1, F_IDATA, 0, "rst_idata");
    expect_at(b+1, F_RREQ,  0, "rst_rreq");
    @(posedge clk);
    #1;
    i_reset = 1'b0;

    // 1: RESET frame held two cycles
    drive(C_RESET, 9'd0, 16'd0, b);
    expect_at(b+1, F_PRST,  1, "t1_prst_hi");
    expect_at(b+1, F_REPLY, 1, "t1_ack");
    expect_at(b+1, F_MODE,  0, "t1_mode");
    expect_at(b+1, F_RUN,   0, "t1_run");
    expect_at(b+2, F_PRST,  0, "t1_prst_lo");
    expect_at(b+3, F_PRST,  0, "t1_prst_lo2");
    finish_cmd();

    drive(C_BAD, 9'd1, 16'd1, b);
    expect_at(b+1, F_REPLY, 32'h3F, "bad_err");
    expect_at(b+1, F_PRST,  0, "bad_prst");
    expect_at(b+1, F_BUSY,  0, "bad_busy");
    finish_cmd();

    // 2: step mode
    drive(C_MSTEP, 9'd0, 16'd0, b);
    expect_at(b+1, F_REPLY, 1, "t2_mstep_ack");
    expect_at(b+1, F_MODE,  1, "t2_mode1");
    finish_cmd();

    drive(C_STEP, 9'd0, 16'd0, b);
    expect_at(b+1, F_REPLY, 32'h3F, "t2_step_err");
    expect_at(b+1, F_PEN,   0, "t2_step_nopen");
    expect_at(b+2, F_PEN,   0, "t2_step_nopen2");
    finish_cmd();

    drive(C_MGET, 9'd0, 16'd0, b);
    expect_at(b+1, F_FRAME, 32'h11000001, "t2_mget");
    finish_cmd();

    drive(C_START, 9'd0, 16'd0, b);
    expect_at(b+1, F_REPLY, 1, "t2_start_ack");
    expect_at(b+1, F_RUN,   1, "t2_run");
    expect_at(b+2, F_PEN,   0, "t2_nocont");
    finish_cmd();

    for (k = 0; k < 3; k++) begin
      drive(C_STEP, 9'd0, 16'd0, b);
      expect_at(b+1, F_PEN,   1, "t2_step_pen");
      expect_at(b+1, F_REPLY, 1, "t2_step_ack");
      expect_at(b+2, F_PEN,   0, "t2_step_pen_lo");
      expect_at(b+3, F_PEN,   0, "t2_step_pen_lo2");
      finish_cmd();
    end

    drive(C_RESET, 9'd0, 16'd0, b);
    expect_at(b+1, F_PRST, 1, "t2_rst_prst");
    expect_at(b+1, F_MODE, 0, "t2_rst_mode");
    expect_at(b+1, F_RUN,  0, "t2_rst_run");
    finish_cmd();

    // 3: instruction load
    drive(C_LSB, 9'd0, 16'h0020, b);
    expect_at(b+1, F_REPLY, 1, "t3_lsb_ack");
    expect_at(b+1, F_IWE,   0, "t3_lsb_nowe");
    finish_cmd();

    drive(C_MSB, 9'd5, 16'h2001, b);
    expect_at(b+1, F_IWE,   1, "t3_we");
    expect_at(b+1, F_IADDR, 5, "t3_iaddr");
    expect_at(b+1, F_IDATA, 32'h20010020, "t3_idata");
    expect_at(b+1, F_REPLY, 1, "t3_msb_ack");
    expect_at(b+2, F_IWE,   0, "t3_we_lo");
    finish_cmd();

    // 4: full read sequence
    drive(C_REQ, 9'd2, 16'd3, b);
    expect_at(b+1, F_RREQ,  1, "t4_rreq");
    expect_at(b+1, F_RTYPE, 2, "t4_rtype");
    expect_at(b+1, F_RADDR, 3, "t4_raddr");
    expect_at(b+1, F_BUSY,  1, "t4_busy");
    expect_at(b+2, F_RREQ,  0, "t4_rreq_lo");
    expect_at(b+3, F_REPLY, 2, "t4_rlsb");
    expect_at(b+3, F_DATA,  32'hBEEF, "t4_lsb_data");
    finish_cmd();

    drive(C_GIB, 9'd0, 16'd0, b);
    expect_at(b+1, F_REPLY, 3, "t4_rmsb");
    expect_at(b+1, F_DATA,  32'hDEAD, "t4_msb_data");
    expect_at(b+1, F_BUSY,  1, "t4_busy_msb");
    finish_cmd();

    drive(C_GOT, 9'd0, 16'd0, b);
    expect_at(b+1, F_REPLY, 1, "t4_got_ack");
    expect_at(b+1, F_BUSY,  0, "t4_idle");
    finish_cmd();

    // 5a: abort in SEND_LSB
    drive(C_REQ, 9'd2, 16'd7, b);
    expect_at(b+3, F_DATA, 32'h5678, "t5_lsb_data");
    finish_cmd();

    drive(C_START, 9'd0, 16'd0, b);
    expect_at(b+1, F_REPLY, 32'h3F, "t5_abort_err");
    expect_at(b+1, F_BUSY,  0, "t5_abort_idle");
    expect_at(b+1, F_RUN,   0, "t5_abort_norun");
    finish_cmd();

    drive(C_GIB, 9'd0, 16'd0, b);
    expect_at(b+1, F_REPLY, 32'h3F, "t5_gib_idle_err");
    finish_cmd();

    // 5b: RESET during RD_WAIT
    drive(C_REQ, 9'd2, 16'd9, b);
    expect_at(b+1, F_RREQ, 1, "t5b_rreq");
    drive(C_RESET, 9'd0, 16'd0, b2);
    expect_at(b2+1, F_PRST,  1, "t5b_prst");
    expect_at(b2+1, F_BUSY,  0, "t5b_idle");
    expect_at(b2+1, F_REPLY, 1, "t5b_ack");
    expect_at(b2+3, F_REPLY, 1, "t5b_no_lsb");
    expect_at(b2+3, F_BUSY,  0, "t5b_idle2");
    finish_cmd();

    // 5c: i_reset mid-read
    drive(C_REQ, 9'd2, 16'd3, b);
    expect_at(b+1, F_BUSY, 1, "t5c_busy");
    @(posedge clk);
    #1;
    i_reset = 1'b1;
    i_frame = '0;
    expect_at(b+2, F_FRAME, 0, "t5c_frame");
    expect_at(b+2, F_RREQ,  0, "t5c_rreq");
    expect_at(b+2, F_RTYPE, 0, "t5c_rtype");
    expect_at(b+2, F_RADDR, 0, "t5c_raddr");
    expect_at(b+2, F_IADDR, 0, "t5c_iaddr");
    expect_at(b+2, F_IDATA, 0, "t5c_idata");
    expect_at(b+4, F_FRAME, 0, "t5c_frame_after");
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    i_reset = 1'b0;

    // 6: continuous run and halt
    drive(C_START, 9'd0, 16'd0, b);
    expect_at(b+1, F_RUN, 1, "t6_run");
    expect_at(b+1, F_PEN, 0, "t6_pen_lat");
    expect_at(b+2, F_PEN, 1, "t6_pen1");
    expect_at(b+3, F_PEN, 1, "t6_pen2");
    finish_cmd();

    drive(C_START, 9'd0, 16'd0, b);
    i_halt = 1'b1;
    expect_at(b+1, F_RUN, 0, "t6_halt_run");
    expect_at(b+1, F_PEN, 1, "t6_halt_pen_still");
    expect_at(b+2, F_PEN, 0, "t6_halt_pen_lo");
    expect_at(b+3, F_PEN, 0, "t6_halt_pen_lo2");
    expect_at(b+3, F_RUN, 0, "t6_halt_run2");
    @(posedge clk);
    #1;
    i_halt = 1'b0;
    @(posedge clk);
    #1;
    i_frame[25] = 1'b0;

    for (k = 0; k < 20 && sb.size() > 0; k++) @(posedge clk);
    @(negedge clk);
    if (sb.size() > 0) begin
      n_fail += sb.size();
      $display("FAIL drain: %0d expectations never checked", sb.size());
    end

    check_count("prst_cycles", cnt_prst, 3);
    check_count("iwe_cycles", cnt_iwe, 1);
    check_count("rreq_cycles", cnt_rreq, 4);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
